// File: rtl/hsv_pkg.sv
// Shared constants, FSM state encoding and hue-sector helper for the HSV to RGB PWM driver.
package hsv_pkg;

   localparam int unsigned HUE_MAX    = 359;
   localparam int unsigned SV_MAX     = 100;
   localparam int unsigned DUTY_MAX   = 255;
   localparam int unsigned SECTOR_DEG = 60;
   localparam int unsigned PWM_STEPS  = 255;

   typedef enum logic [2:0] {
      IDLE,
      DIV_V,
      DIV_C,
      DIV_X,
      MIX
   } state_t;

   typedef logic [2:0] sector_t;

   function automatic sector_t hue_sector(input logic [8:0] h);
      sector_t s;
      if      (h < 9'(SECTOR_DEG * 1)) s = 3'd0;
      else if (h < 9'(SECTOR_DEG * 2)) s = 3'd1;
      else if (h < 9'(SECTOR_DEG * 3)) s = 3'd2;
      else if (h < 9'(SECTOR_DEG * 4)) s = 3'd3;
      else if (h < 9'(SECTOR_DEG * 5)) s = 3'd4;
      else                             s = 3'd5;
      return s;
   endfunction

endpackage

// File: rtl/seq_divider.sv
// Restoring divider: the start cycle performs the first step, done pulses with the final quotient DIV_W cycles later.
module seq_divider #(
   parameter int unsigned DIV_W = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [DIV_W-1:0] dividend,
   input  logic [6:0]       divisor,
   output logic [DIV_W-1:0] quotient,
   output logic             done
);

   localparam int unsigned CNT_W = $clog2(DIV_W + 1);

   logic [6:0]       rem;
   logic [6:0]       dvs;
   logic [CNT_W-1:0] cnt;
   logic             running;

   logic [6:0]       src_rem;
   logic [6:0]       src_dvs;
   logic [DIV_W-1:0] src_quo;
   logic [7:0]       trial;
   logic             ge;
   logic [6:0]       rem_next;
   logic [DIV_W-1:0] quo_next;

   always_comb begin
      src_rem  = start ? '0 : rem;
      src_quo  = start ? dividend : quotient;
      src_dvs  = start ? divisor : dvs;
      trial    = {src_rem, src_quo[DIV_W-1]};
      ge       = (trial >= {1'b0, src_dvs});
      rem_next = ge ? 7'(trial - {1'b0, src_dvs}) : trial[6:0];
      quo_next = {src_quo[DIV_W-2:0], ge};
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         rem      <= '0;
         dvs      <= '0;
         quotient <= '0;
         cnt      <= '0;
         running  <= 1'b0;
         done     <= 1'b0;
      end else begin
         done <= 1'b0;
         if (start) begin
            rem      <= rem_next;
            quotient <= quo_next;
            dvs      <= divisor;
            cnt      <= CNT_W'(DIV_W - 1);
            running  <= 1'b1;
         end else if (running) begin
            rem      <= rem_next;
            quotient <= quo_next;
            cnt      <= cnt - 1'b1;
            if (cnt == CNT_W'(1)) begin
               running <= 1'b0;
               done    <= 1'b1;
            end
         end
      end
   end

endmodule

// File: rtl/hsv_rgb_pwm.sv
// HSV to RGB duty conversion over a shared sequential divider, driving three PWM LED outputs.
// Define HSV_COMMON_ANODE_EN for active-low (common-anode) LED outputs.
module hsv_rgb_pwm
   import hsv_pkg::*;
#(
   parameter int unsigned DIV_W   = 16,
   parameter int unsigned PWM_DIV = 392
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [8:0] Hue,
   input  logic [8:0] Saturation,
   input  logic [8:0] Value,
   output logic [7:0] R,
   output logic [7:0] G,
   output logic [7:0] B,
   output logic       rgb_valid,
   output logic       busy,
   output logic       led_r,
   output logic       led_g,
   output logic       led_b
);

`ifdef HSV_COMMON_ANODE_EN
   localparam logic LED_INV = 1'b1;
`else
   localparam logic LED_INV = 1'b0;
`endif
   localparam int unsigned PRE_W = (PWM_DIV > 1) ? $clog2(PWM_DIV) : 1;

   state_t           state, next_state;
   logic [26:0]      hsv_cap;
   logic [8:0]       h_n;
   logic [6:0]       s_n, v_n;
   logic [7:0]       v8, c_val, x_val, m_val;
   logic             started, mix_phase;

   logic [8:0]       h_in;
   logic [6:0]       s_in, v_in;
   logic             changed;
   sector_t          sector;
   logic [5:0]       f, f_eff;
   logic [7:0]       cm, xm;

   logic             capture, div_start, write_rgb;
   logic [DIV_W-1:0] div_dividend, div_q;
   logic [6:0]       div_divisor;
   logic             div_done;

   logic [PRE_W-1:0] pre;
   logic [7:0]       pwm_cnt;

   always_comb begin
      h_in    = (Hue > 9'(HUE_MAX)) ? Hue - 9'(HUE_MAX + 1) : Hue;
      s_in    = (Saturation > 9'(SV_MAX)) ? 7'(SV_MAX) : Saturation[6:0];
      v_in    = (Value > 9'(SV_MAX)) ? 7'(SV_MAX) : Value[6:0];
      changed = ({Hue, Saturation, Value} != hsv_cap);
      sector  = hue_sector(h_n);
      f       = 6'(h_n - 9'(SECTOR_DEG) * {6'b0, sector});
      f_eff   = sector[0] ? 6'(SECTOR_DEG) - f : f;
      cm      = c_val + m_val;
      xm      = x_val + m_val;
   end

   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= next_state;
   end

   always_comb begin
      next_state = state;
      unique case (state)
         IDLE:    if (changed)   next_state = DIV_V;
         DIV_V:   if (div_done)  next_state = DIV_C;
         DIV_C:   if (div_done)  next_state = DIV_X;
         DIV_X:   if (div_done)  next_state = MIX;
         MIX:     if (mix_phase) next_state = IDLE;
         default:                next_state = IDLE;
      endcase
   end

   // Start is issued in the first cycle of each DIV state, once operands are registered.
   always_comb begin
      capture      = 1'b0;
      div_start    = 1'b0;
      write_rgb    = 1'b0;
      div_dividend = '0;
      div_divisor  = 7'(SV_MAX);
      unique case (state)
         IDLE:  capture = changed;
         DIV_V: begin
            div_start    = !started;
            div_dividend = DIV_W'(v_n) * DIV_W'(DUTY_MAX);
         end
         DIV_C: begin
            div_start    = !started;
            div_dividend = DIV_W'(v8) * DIV_W'(s_n);
         end
         DIV_X: begin
            div_start    = !started;
            div_dividend = DIV_W'(c_val) * DIV_W'(f_eff);
            div_divisor  = 7'(SECTOR_DEG);
         end
         MIX:     write_rgb = mix_phase;
         default: ;
      endcase
   end

   seq_divider #(.DIV_W(DIV_W)) u_div (
      .clk      (clk),
      .reset    (reset),
      .start    (div_start),
      .dividend (div_dividend),
      .divisor  (div_divisor),
      .quotient (div_q),
      .done     (div_done)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         hsv_cap   <= '0;
         h_n       <= '0;
         s_n       <= '0;
         v_n       <= '0;
         v8        <= '0;
         c_val     <= '0;
         x_val     <= '0;
         m_val     <= '0;
         started   <= 1'b0;
         mix_phase <= 1'b0;
         R         <= '0;
         G         <= '0;
         B         <= '0;
         rgb_valid <= 1'b0;
         busy      <= 1'b0;
      end else begin
         rgb_valid <= 1'b0;
         if (capture) begin
            hsv_cap <= {Hue, Saturation, Value};
            h_n     <= h_in;
            s_n     <= s_in;
            v_n     <= v_in;
            busy    <= 1'b1;
         end
         if (div_done)       started <= 1'b0;
         else if (div_start) started <= 1'b1;
         if (div_done && state == DIV_V) v8    <= 8'(div_q);
         if (div_done && state == DIV_C) c_val <= 8'(div_q);
         if (div_done && state == DIV_X) x_val <= 8'(div_q);
         mix_phase <= (state == MIX) && !mix_phase;
         if (state == MIX && !mix_phase) m_val <= v8 - c_val;
         if (write_rgb) begin
            unique case (sector)
               3'd0:    begin R <= cm;    G <= xm;    B <= m_val; end
               3'd1:    begin R <= xm;    G <= cm;    B <= m_val; end
               3'd2:    begin R <= m_val; G <= cm;    B <= xm;    end
               3'd3:    begin R <= m_val; G <= xm;    B <= cm;    end
               3'd4:    begin R <= xm;    G <= m_val; B <= cm;    end
               default: begin R <= cm;    G <= m_val; B <= xm;    end
            endcase
            rgb_valid <= 1'b1;
            busy      <= 1'b0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         pre     <= '0;
         pwm_cnt <= '0;
         led_r   <= LED_INV;
         led_g   <= LED_INV;
         led_b   <= LED_INV;
      end else begin
         if (pre == PRE_W'(PWM_DIV - 1)) begin
            pre     <= '0;
            pwm_cnt <= (pwm_cnt == 8'(PWM_STEPS - 1)) ? '0 : pwm_cnt + 1'b1;
         end else begin
            pre <= pre + 1'b1;
         end
         led_r <= (pwm_cnt < R) ^ LED_INV;
         led_g <= (pwm_cnt < G) ^ LED_INV;
         led_b <= (pwm_cnt < B) ^ LED_INV;
      end
   end

endmodule

// File: tb/tb_hsv_rgb_pwm.sv
// Directed bench for hsv_rgb_pwm: conversion results, latency, retrigger, reset abort and PWM duty counts.
module tb_hsv_rgb_pwm;

   logic       clk = 1'b0;
   logic       reset;
   logic [8:0] Hue, Saturation, Value;
   logic [7:0] R, G, B;
   logic       rgb_valid, busy, led_r, led_g, led_b;

   int checks   = 0;
   int failures = 0;

`ifdef HSV_COMMON_ANODE_EN
   localparam logic ANODE = 1'b1;
`else
   localparam logic ANODE = 1'b0;
`endif

   always #5 clk = ~clk;

   hsv_rgb_pwm #(.DIV_W(16), .PWM_DIV(1)) dut (
      .clk        (clk),
      .reset      (reset),
      .Hue        (Hue),
      .Saturation (Saturation),
      .Value      (Value),
      .R          (R),
      .G          (G),
      .B          (B),
      .rgb_valid  (rgb_valid),
      .busy       (busy),
      .led_r      (led_r),
      .led_g      (led_g),
      .led_b      (led_b)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic set_hsv(input string tag, input int h, input int s, input int v);
      @(negedge clk);
      Hue        = 9'(h);
      Saturation = 9'(s);
      Value      = 9'(v);
      @(negedge clk);
      check({tag, "_busy_rise"}, 32'(busy), 32'd1);
   endtask

   task automatic wait_result(input string tag, input int lat, input int er, input int eg, input int eb);
      int n = 0;
      while (rgb_valid !== 1'b1 && n < 200) begin
         @(negedge clk);
         n++;
      end
      check({tag, "_latency"}, 32'(n), 32'(lat));
      check({tag, "_R"}, 32'(R), 32'(er));
      check({tag, "_G"}, 32'(G), 32'(eg));
      check({tag, "_B"}, 32'(B), 32'(eb));
      check({tag, "_busy_low"}, 32'(busy), 32'd0);
      @(negedge clk);
      check({tag, "_valid_pulse"}, 32'(rgb_valid), 32'd0);
   endtask

   task automatic pwm_count(input string tag, input int er, input int eg, input int eb);
      int cr = 0, cg = 0, cb = 0;
      repeat (255) begin
         @(negedge clk);
         if ((led_r ^ ANODE) === 1'b1) cr++;
         if ((led_g ^ ANODE) === 1'b1) cg++;
         if ((led_b ^ ANODE) === 1'b1) cb++;
      end
      check({tag, "_led_r_on"}, 32'(cr), 32'(er));
      check({tag, "_led_g_on"}, 32'(cg), 32'(eg));
      check({tag, "_led_b_on"}, 32'(cb), 32'(eb));
   endtask

   initial begin
      reset      = 1'b1;
      Hue        = 9'd120;
      Saturation = 9'd80;
      Value      = 9'd80;
      repeat (3) @(negedge clk);
      check("rst_R", 32'(R), 32'd0);
      check("rst_G", 32'(G), 32'd0);
      check("rst_B", 32'(B), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_valid", 32'(rgb_valid), 32'd0);
      check("rst_led_r", 32'(led_r), 32'(ANODE));
      check("rst_led_g", 32'(led_g), 32'(ANODE));
      check("rst_led_b", 32'(led_b), 32'(ANODE));

      reset = 1'b0;
      @(negedge clk);
      check("first_busy_rise", 32'(busy), 32'd1);
      wait_result("h120_s80_v80", 53, 41, 204, 41);

      repeat (3) @(negedge clk);
      check("idle_hold_busy", 32'(busy), 32'd0);

      set_hsv("h0", 0, 100, 100);
      wait_result("h0", 53, 255, 0, 0);
      pwm_count("pwm_red", 255, 0, 0);

      set_hsv("h360", 360, 100, 100);
      wait_result("h360", 53, 255, 0, 0);

      set_hsv("h90", 90, 100, 100);
      wait_result("h90", 53, 127, 255, 0);

      // Hue changes 10 cycles into the H=0 conversion.
      set_hsv("mid", 0, 100, 100);
      repeat (9) @(negedge clk);
      Hue = 9'd60;
      wait_result("mid_first", 44, 255, 0, 0);
      check("mid_rebusy", 32'(busy), 32'd1);
      wait_result("mid_second", 53, 255, 255, 0);

      set_hsv("grey", 200, 0, 50);
      wait_result("grey", 53, 127, 127, 127);

      set_hsv("clamp", 200, 0, 150);
      wait_result("clamp", 53, 255, 255, 255);

      set_hsv("green", 120, 100, 100);
      wait_result("green", 53, 0, 255, 0);
      pwm_count("pwm_green", 0, 255, 0);

      set_hsv("half", 120, 50, 100);
      wait_result("half", 53, 128, 255, 128);
      pwm_count("pwm_half", 128, 255, 128);

      // Reset 30 cycles into a conversion aborts it; it restarts from the zero capture.
      set_hsv("abort", 240, 100, 100);
      repeat (29) @(negedge clk);
      reset = 1'b1;
      repeat (2) @(negedge clk);
      check("abort_busy", 32'(busy), 32'd0);
      check("abort_valid", 32'(rgb_valid), 32'd0);
      check("abort_R", 32'(R), 32'd0);
      check("abort_G", 32'(G), 32'd0);
      check("abort_B", 32'(B), 32'd0);
      check("abort_led_r", 32'(led_r), 32'(ANODE));
      check("abort_led_g", 32'(led_g), 32'(ANODE));
      reset = 1'b0;
      @(negedge clk);
      check("restart_busy_rise", 32'(busy), 32'd1);
      wait_result("restart", 53, 0, 0, 255);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/hsv_rgb_pwm.md
Name: hsv_rgb_pwm

Overview:
- Downstream consumer of the HSV setpoint block.
- Takes Hue (0..359), Saturation (0..100) and Value (0..100) and converts them to 8-bit R/G/B duty values with a multi-cycle integer FSM built on a shared sequential divider.
- Drives three PWM outputs to the board RGB LED.
- Recomputes automatically whenever the HSV inputs change.

Parameters:
- DIV_W, 16, dividend/quotient width of the sequential divider; one division takes DIV_W cycles.
- PWM_DIV, 392, clk cycles per PWM counter tick (100 MHz / 255 / 392 ≈ 1 kHz PWM frame).

Ports:
- clk  input  1  system clock.
- reset  input  1  synchronous, active-high reset.
- Hue  input  9  hue in degrees.
- Saturation  input  9  saturation in percent.
- Value  input  9  value in percent.
- R, G, B  output  8 each  registered duty values.
- rgb_valid  output  1  one-cycle pulse when R/G/B update.
- busy  output  1  high while a conversion is in progress.
- led_r, led_g, led_b  output  1 each  PWM outputs.

Behaviour:
- One clock, clk. Reset is synchronous and active-high on `reset`.
- Reset values:
  - R, G, B, rgb_valid, busy and the led outputs are 0.
  - The captured HSV registers are 0.
  - The PWM counters are 0.
  - FSM goes to IDLE.
- Trigger:
  - In IDLE, if {Hue,Saturation,Value} differs from the captured copy, capture it (cycle 0) and set busy.
  - Input changes while busy are not lost: they are compared again on return to IDLE.
  - After reset, the inputs are always compared against the all-zero captured copy.
- Normalisation at capture:
  - h = Hue ≥ 360 ? Hue − 360 : Hue.
  - s = min(Saturation, 100); v = min(Value, 100).
- FSM states: IDLE → DIV_V → DIV_C → DIV_X → MIX → IDLE.
  - DIV_V: V8 = (v·255)/100.
  - DIV_C: C = (V8·s)/100.
  - DIV_X: sector = h/60 (compare chain, 0..5) and f = h − 60·sector.
    - Even sector: X = (C·f)/60.
    - Odd sector: X = (C·(60−f))/60.
  - MIX: m = V8 − C. Per sector, (R,G,B) − m is:
    - 0: (C,X,0)
    - 1: (X,C,0)
    - 2: (0,C,X)
    - 3: (0,X,C)
    - 4: (X,0,C)
    - 5: (C,0,X)
  - All divisions truncate. Intermediate products use DIV_W bits; the maximum product 255·100 = 25500 fits in 16 bits.
- Latency:
  - Each DIV state issues a start and waits for done (DIV_W + 1 cycles).
  - R/G/B and rgb_valid update exactly 3·(DIV_W+1)+2 = 53 cycles after the capture cycle.
  - busy drops in the same cycle rgb_valid pulses.
- PWM:
  - A prescaler counts 0..PWM_DIV−1.
  - On wrap, pwm_cnt advances 0..254, wrapping to 0.
  - led_x = (pwm_cnt < X_duty), using registered R/G/B.
  - Duty 0 gives always-off; duty 255 gives always-on.
  - New duty values take effect immediately, mid-frame.
- Reset during conversion: aborts, divider cleared, outputs return to reset values.

Optional Feature:
- Macro: HSV_COMMON_ANODE_EN.
- When defined: led_r/g/b are inverted (active-low LED); in reset they are 1.
- When undefined: active-high as above.
- R/G/B values are identical in both builds.

Decomposition:
- Package hsv_pkg holds:
  - Constants HUE_MAX = 359, SV_MAX = 100, DUTY_MAX = 255, SECTOR_DEG = 60, PWM_STEPS = 255.
  - The FSM state enum.
  - A 3-bit sector typedef.
- Sub-module seq_divider:
  - Restoring divider with start/done handshake.
  - DIV_W-bit dividend, 7-bit divisor, DIV_W-cycle latency.
  - Synchronous active-high `reset`.
  - Instantiated once and shared by the three DIV states.

Test Plan:
- Reset with any inputs → R=G=B=0, busy=0, leds=0 (1 with HSV_COMMON_ANODE_EN). Then H=120,S=80,V=80 → after 53 cycles R=41, G=204, B=41 and a single rgb_valid pulse.
- H=0,S=100,V=100 → (255,0,0). H=360,S=100,V=100 → (255,0,0). H=90,S=100,V=100 → (127,255,0).
- H=200,S=0,V=50 → (127,127,127). Then V=150 with S=0 → (255,255,255), clamped.
- Change H from 0 to 60 at cycle 10 of a conversion → the first result corresponds to H=0. busy re-asserts the cycle after busy drops, and the second result, (255,255,0), arrives 53 cycles after that re-capture.
- PWM with PWM_DIV=1 over 255 ticks: R=0 → led_r high 0 ticks; R=255 → 255 ticks; R=128 → exactly 128 ticks.
- Assert reset at cycle 30 of a conversion → no rgb_valid, busy=0, outputs at reset values. The conversion restarts after reset releases.
